// File: rtl/acc_stream_if.sv
// Valid/ready stream bundle used on both sides of acc_stream.
// Carries one data word per handshake.
interface acc_stream_if #(
  parameter int WIDTH = 9
) ();
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/acc_stream.sv
// Multi-cycle accumulator: sums K adder results and
// presents the full-precision total over a handshake.
module acc_stream #(
  parameter int N      = 8,
  parameter int K      = 4,
  parameter bit SIGNED = 1'b1
) (
  input  logic  clk,
  input  logic  rst,
  acc_stream_if.slave  in_s,
  acc_stream_if.master out_m,
  output logic  out_cnt_err
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam int W  = N + 1 + CW;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  ext;
  logic          accept;
  logic          last;

  // K outside 2..256 cannot be built correctly
  assign out_cnt_err = (K < 2) || (K > 256);

  // Widen the incoming word to the accumulator width
  always_comb begin
    if (SIGNED)
      ext = {{CW{in_s.data[N]}}, in_s.data};
    else
      ext = {{CW{1'b0}}, in_s.data};
  end

  // Handshake outputs decoded from state only
  always_comb begin
    in_s.ready = (state_q == ACCUM) && !rst;
    out_m.valid = (state_q == HOLD);
    out_m.data = acc_q;
  end

  assign accept = in_s.valid && in_s.ready;
  assign last   = (cnt_q == LAST);

  // Next-state: finish on K-th accept, release on handshake
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM: if (accept && last) state_d = HOLD;
      HOLD:  if (out_m.ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Datapath: first operand loads, later ones add
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (accept) begin
      if (cnt_q == '0)
        acc_d = ext;
      else
        acc_d = acc_q + ext;
      if (last)
        cnt_d = '0;
      else
        cnt_d = cnt_q + 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state_q <= ACCUM;
    else
      state_q <= state_d;
  end

  // Accumulator and operand counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_acc_stream.sv
// Directed bench for acc_stream: signed and unsigned
// instances, bubbles, backpressure, reset, streaming.
module tb_acc_stream;

  logic clk;
  logic rst;
  logic s_err;
  logic u_err;
  int   n_checks;
  int   n_fail;

  acc_stream_if #(.WIDTH(9))  s_in ();
  acc_stream_if #(.WIDTH(11)) s_out ();
  acc_stream_if #(.WIDTH(9))  u_in ();
  acc_stream_if #(.WIDTH(11)) u_out ();

  acc_stream #(.N(8), .K(4), .SIGNED(1'b1)) dut_s (
    .clk         (clk),
    .rst         (rst),
    .in_s        (s_in),
    .out_m       (s_out),
    .out_cnt_err (s_err)
  );

  acc_stream #(.N(8), .K(4), .SIGNED(1'b0)) dut_u (
    .clk         (clk),
    .rst         (rst),
    .in_s        (u_in),
    .out_m       (u_out),
    .out_cnt_err (u_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_s(input logic [8:0] v);
    s_in.valid = 1'b1;
    s_in.data  = v;
    cyc();
  endtask

  task automatic feed_u(input logic [8:0] v);
    u_in.valid = 1'b1;
    u_in.data  = v;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_in.valid = 1'b0;
    s_in.data = '0;
    s_out.ready = 1'b0;
    u_in.valid = 1'b0;
    u_in.data = '0;
    u_out.ready = 1'b0;
    cyc();
    cyc();
    n_checks++;
    if (s_in.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ready_low: got %b want 0", s_in.ready);
    end
    n_checks++;
    if (s_out.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid: got %b want 0", s_out.valid);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (s_in.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_rst_ready: got %b want 1", s_in.ready);
    end
    n_checks++;
    if (s_out.data !== 11'd0) begin
      n_fail++;
      $display("FAIL post_rst_data: got %h want 000", s_out.data);
    end
    n_checks++;
    if (s_out.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst_valid: got %b want 0", s_out.valid);
    end
    n_checks++;
    if (s_err !== 1'b0 || u_err !== 1'b0) begin
      n_fail++;
      $display("FAIL cnt_err: got %b%b want 00", s_err, u_err);
    end
    n_checks++;
    if (u_in.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL u_post_rst_ready: got %b want 1", u_in.ready);
    end
  endtask

  task automatic test_signed_mix();
    s_out.ready = 1'b1;
    feed_s(9'd100);
    feed_s(9'd200);
    feed_s(9'h1CE);
    feed_s(9'd3);
    s_in.valid = 1'b0;
    n_checks++;
    if (s_out.valid !== 1'b1 || s_out.data !== 11'd253) begin
      n_fail++;
      $display("FAIL mix_sum: got v=%b d=%h want v=1 d=0fd",
               s_out.valid, s_out.data);
    end
    n_checks++;
    if (s_in.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mix_hold_ready: got %b want 0", s_in.ready);
    end
    cyc();
    n_checks++;
    if (s_in.ready !== 1'b1 || s_out.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mix_release: got r=%b v=%b want r=1 v=0",
               s_in.ready, s_out.valid);
    end
  endtask

  task automatic test_signed_extremes();
    s_out.ready = 1'b1;
    repeat (4) feed_s(9'h100);
    s_in.valid = 1'b0;
    n_checks++;
    if (s_out.valid !== 1'b1 || s_out.data !== 11'h400) begin
      n_fail++;
      $display("FAIL neg_max: got v=%b d=%h want v=1 d=400",
               s_out.valid, s_out.data);
    end
    cyc();
    repeat (4) feed_s(9'h0FF);
    s_in.valid = 1'b0;
    n_checks++;
    if (s_out.valid !== 1'b1 || s_out.data !== 11'd1020) begin
      n_fail++;
      $display("FAIL pos_max: got v=%b d=%h want v=1 d=3fc",
               s_out.valid, s_out.data);
    end
    cyc();
  endtask

  task automatic test_unsigned();
    u_out.ready = 1'b1;
    repeat (4) feed_u(9'h1FF);
    u_in.valid = 1'b0;
    n_checks++;
    if (u_out.valid !== 1'b1 || u_out.data !== 11'd2044) begin
      n_fail++;
      $display("FAIL unsigned: got v=%b d=%h want v=1 d=7fc",
               u_out.valid, u_out.data);
    end
    cyc();
    n_checks++;
    if (u_out.valid !== 1'b0 || u_in.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL u_release: got v=%b r=%b want v=0 r=1",
               u_out.valid, u_in.ready);
    end
  endtask

  task automatic test_bubbles();
    logic       vld [7];
    logic [8:0] dat [7];
    vld = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    dat = '{9'd10, 9'd99, 9'd77, 9'd20, 9'd30, 9'd55, 9'd40};
    s_out.ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      s_in.valid = vld[i];
      s_in.data  = dat[i];
      cyc();
    end
    s_in.valid = 1'b1;
    s_in.data  = 9'd5;
    n_checks++;
    if (s_out.valid !== 1'b1 || s_out.data !== 11'd100) begin
      n_fail++;
      $display("FAIL bub_sum: got v=%b d=%h want v=1 d=064",
               s_out.valid, s_out.data);
    end
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_checks++;
      if (s_out.valid !== 1'b1 || s_out.data !== 11'd100 ||
          s_in.ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bub_stall%0d: got v=%b d=%h r=%b want 1 064 0",
                 i, s_out.valid, s_out.data, s_in.ready);
      end
    end
    s_out.ready = 1'b1;
    cyc();
    n_checks++;
    if (s_in.ready !== 1'b1 || s_out.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bub_release: got r=%b v=%b want r=1 v=0",
               s_in.ready, s_out.valid);
    end
    cyc();
    feed_s(9'd1);
    feed_s(9'd2);
    feed_s(9'd3);
    s_in.valid = 1'b0;
    n_checks++;
    if (s_out.valid !== 1'b1 || s_out.data !== 11'd11) begin
      n_fail++;
      $display("FAIL bub_nocons: got v=%b d=%h want v=1 d=00b",
               s_out.valid, s_out.data);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    s_out.ready = 1'b1;
    feed_s(9'd7);
    feed_s(9'd8);
    s_in.valid = 1'b0;
    rst = 1'b1;
    cyc();
    n_checks++;
    if (s_in.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_ready: got %b want 0", s_in.ready);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (s_in.ready !== 1'b1 || s_out.data !== 11'd0) begin
      n_fail++;
      $display("FAIL mid_rst_clear: got r=%b d=%h want r=1 d=000",
               s_in.ready, s_out.data);
    end
    feed_s(9'd1);
    feed_s(9'd2);
    feed_s(9'd3);
    feed_s(9'd4);
    s_in.valid = 1'b0;
    n_checks++;
    if (s_out.valid !== 1'b1 || s_out.data !== 11'd10) begin
      n_fail++;
      $display("FAIL mid_rst_sum: got v=%b d=%h want v=1 d=00a",
               s_out.valid, s_out.data);
    end
    cyc();
    feed_s(9'd1);
    feed_s(9'd1);
    feed_s(9'd1);
    s_in.valid = 1'b1;
    s_in.data = 9'd1;
    rst = 1'b1;
    cyc();
    s_in.valid = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++;
    if (s_out.valid !== 1'b0 || s_out.data !== 11'd0) begin
      n_fail++;
      $display("FAIL rst_kth: got v=%b d=%h want v=0 d=000",
               s_out.valid, s_out.data);
    end
    repeat (4) feed_s(9'd2);
    s_in.valid = 1'b0;
    n_checks++;
    if (s_out.valid !== 1'b1 || s_out.data !== 11'd8) begin
      n_fail++;
      $display("FAIL rst_kth_next: got v=%b d=%h want v=1 d=008",
               s_out.valid, s_out.data);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    n_checks++;
    if (s_out.valid !== 1'b0 || s_out.data !== 11'd0) begin
      n_fail++;
      $display("FAIL rst_hs: got v=%b d=%h want v=0 d=000",
               s_out.valid, s_out.data);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0]  vals [12];
    logic [10:0] exp  [3];
    int p;
    int k;
    vals = '{9'd1, 9'd2, 9'd3, 9'd4,
             9'h1FF, 9'h1FE, 9'h1FD, 9'h1FC,
             9'd50, 9'd60, 9'd70, 9'd80};
    exp = '{11'd10, 11'h7F6, 11'd260};
    s_out.ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      p = c % 5;
      k = c / 5;
      s_in.valid = 1'b1;
      s_in.data = (p < 4) ? vals[k*4+p] : 9'h0AA;
      cyc();
      if (p == 3) begin
        n_checks++;
        if (s_out.valid !== 1'b1 || s_out.data !== exp[k]) begin
          n_fail++;
          $display("FAIL b2b_sum%0d: got v=%b d=%h want v=1 d=%h",
                   k, s_out.valid, s_out.data, exp[k]);
        end
      end
      if (p == 4) begin
        n_checks++;
        if (s_out.valid !== 1'b0 || s_in.ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_rel%0d: got v=%b r=%b want v=0 r=1",
                   k, s_out.valid, s_in.ready);
        end
      end
    end
    s_in.valid = 1'b0;
    cyc();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_signed_mix();
    test_signed_extremes();
    test_unsigned();
    test_bubbles();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
